// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal byte-wide register file. SCL/SDA are
// oversampled on clk; writes auto-increment the register pointer and
// reads are reached through a repeated START after the pointer byte.
module i2c_slave_regfile #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  input  logic [6:0] slave_addr,
  input  logic [7:0] rst_val
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Each ACK slot is its own state so the falling edge that ends it is
  // unambiguous; bytes are framed by a bit counter inside the data states.
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t          state;
  logic            scl_s1, scl_s2, scl_d;
  logic            sda_s1, sda_s2, sda_d;
  logic            sda_oe;
  logic [7:0]      shreg;
  logic [3:0]      cnt;
  logic            rw;
  logic [AW-1:0]   ptr;
  logic [7:0]      regs [DEPTH];

  logic scl_rise, scl_fall, start_c, stop_c, rx_state;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_state = (state == ADDR) || (state == REG) || (state == WDATA);

  // Two-flop synchronizers plus a previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl;  scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda;  sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Protocol FSM, register file and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
      cnt    <= '0;
      shreg  <= '0;
      rw     <= 1'b0;
      ptr    <= rst_val[AW-1:0];
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= rst_val;
    end else if (start_c) begin
      state  <= ADDR;
      cnt    <= '0;
      sda_oe <= 1'b0;
    end else if (stop_c) begin
      state  <= IDLE;
      cnt    <= '0;
      sda_oe <= 1'b0;
    end else begin
      if (scl_rise && rx_state && cnt != 4'd8) begin
        shreg <= {shreg[6:0], sda_s2};
        cnt   <= cnt + 4'd1;
      end
      case (state)
        ADDR: if (scl_fall && cnt == 4'd8) begin
          cnt <= '0;
          if (shreg[7:1] == slave_addr) begin
            rw     <= shreg[0];
            sda_oe <= 1'b1;
            state  <= ADDR_ACK;
          end else begin
            state  <= IDLE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw) begin
            shreg  <= regs[ptr];
            sda_oe <= ~regs[ptr][7];
            state  <= RDATA;
          end else begin
            sda_oe <= 1'b0;
            state  <= REG;
          end
        end
        REG: if (scl_fall && cnt == 4'd8) begin
          cnt    <= '0;
          ptr    <= shreg[AW-1:0];
          sda_oe <= 1'b1;
          state  <= REG_ACK;
        end
        REG_ACK: if (scl_fall) begin
          sda_oe <= 1'b0;
          state  <= WDATA;
        end
        WDATA: if (scl_fall && cnt == 4'd8) begin
          cnt        <= '0;
          regs[ptr]  <= shreg;
          ptr        <= ptr + 1'b1;
          sda_oe     <= 1'b1;
          state      <= WDATA_ACK;
        end
        WDATA_ACK: if (scl_fall) begin
          sda_oe <= 1'b0;
          state  <= WDATA;
        end
        RDATA: if (scl_fall) begin
          if (cnt == 4'd7) begin
            cnt    <= '0;
            sda_oe <= 1'b0;
            state  <= RACK;
          end else begin
            cnt    <= cnt + 4'd1;
            shreg  <= {shreg[6:0], 1'b0};
            sda_oe <= ~shreg[6];
          end
        end
        // A falling edge can only reach here after an ACK was sampled.
        RACK: begin
          if (scl_rise) begin
            if (sda_s2) state <= IDLE;
            else        ptr   <= ptr + 1'b1;
          end else if (scl_fall) begin
            shreg  <= regs[ptr];
            sda_oe <= ~regs[ptr][7];
            cnt    <= '0;
            state  <= RDATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: bit-banged I2C controller
// against a transaction-level model of the register file and pointer.
module tb_i2c_slave_regfile;

  localparam int          Q  = 40;
  localparam logic [6:0]  MY = 7'h11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       ctl_oe = 1'b0;
  logic [7:0] rst_val = 8'h00;
  wire        sda_bus;

  pullup pu (sda_bus);
  assign sda_bus = ctl_oe ? 1'b0 : 1'bz;

  i2c_slave_regfile #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .slave_addr(MY), .rst_val(rst_val)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  wr_buf [16];
  logic [7:0]  rd_buf [16];
  logic [7:0]  exp_buf [16];
  logic        post_bit;
  logic [7:0]  mregs [16];
  int unsigned mptr;

  // ---------------- reference model ----------------
  task automatic m_reset(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mregs[i] = v;
    mptr = v % 16;
  endtask

  task automatic m_write(input int unsigned r, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) mregs[(r + i) % 16] = wr_buf[i];
    mptr = (r + n) % 16;
  endtask

  task automatic m_read(input logic set, input int unsigned r, input int unsigned n);
    int unsigned s;
    s = set ? (r % 16) : mptr;
    for (int unsigned i = 0; i < n; i++) exp_buf[i] = mregs[(s + i) % 16];
    mptr = (s + n - 1) % 16;
  endtask

  // ---------------- bus controller ----------------
  task automatic wbit(input logic b);
    ctl_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    ctl_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    ctl_oe = 1'b0; #Q; scl = 1'b1; #Q; ctl_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    ctl_oe = 1'b1; #Q; scl = 1'b1; #Q; ctl_oe = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    acked = (a == 1'b0);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    logic x;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      rbit(x);
      b = {b[6:0], x};
    end
    wbit(nack);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] r,
                          input int unsigned n, output int unsigned acks);
    logic ok;
    acks = 0;
    i2c_start;
    wbyte({a, 1'b0}, ok); if (ok) acks++;
    wbyte(r, ok);         if (ok) acks++;
    for (int unsigned i = 0; i < n; i++) begin
      wbyte(wr_buf[i], ok); if (ok) acks++;
    end
    i2c_stop;
  endtask

  task automatic do_read(input logic [6:0] a, input logic set, input logic [7:0] r,
                         input int unsigned n, output int unsigned acks);
    logic ok;
    logic [7:0] b;
    acks = 0;
    i2c_start;
    if (set) begin
      wbyte({a, 1'b0}, ok); if (ok) acks++;
      wbyte(r, ok);         if (ok) acks++;
      i2c_start;
    end
    wbyte({a, 1'b1}, ok); if (ok) acks++;
    for (int unsigned i = 0; i < n; i++) begin
      rbyte(i == n - 1, b);
      rd_buf[i] = b;
    end
    rbit(post_bit);
    i2c_stop;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic low_seen, ok;
    rst_val = 8'h00; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_reset(8'h00);
    low_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sda_bus !== 1'b1) low_seen = 1'b1;
    end
    checks++;
    if (low_seen !== 1'b0) begin
      errors++; $display("FAIL reset_idle_sda: low_seen=%0b required 0", low_seen);
    end
    wbyte({MY, 1'b0}, ok);
    checks++;
    if (ok !== 1'b0) begin
      errors++; $display("FAIL ack_without_start: ack=%0b required 0", ok);
    end
    i2c_stop;
  endtask

  task automatic test_readback_all(input string tag);
    int unsigned acks;
    do_read(MY, 1'b1, 8'h00, 16, acks);
    m_read(1'b1, 0, 16);
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL %s_acks: got %0d required 3", tag, acks);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_buf[i] !== exp_buf[i]) begin
        errors++; $display("FAIL %s_reg%0d: got %02h required %02h", tag, i, rd_buf[i], exp_buf[i]);
      end
    end
  endtask

  task automatic test_write_burst;
    int unsigned acks;
    for (int i = 0; i < 8; i++) wr_buf[i] = 8'(i + 1);
    do_write(MY, 8'h00, 8, acks);
    m_write(0, 8);
    checks++;
    if (acks !== 10) begin
      errors++; $display("FAIL burst_acks: got %0d required 10", acks);
    end
    // current-address read exposes the pointer left by the burst
    do_read(MY, 1'b0, 8'h00, 1, acks);
    m_read(1'b0, 0, 1);
    checks++;
    if (acks !== 1 || rd_buf[0] !== exp_buf[0] || mptr != 8) begin
      errors++; $display("FAIL burst_pointer: acks=%0d data=%02h required acks=1 data=%02h", acks, rd_buf[0], exp_buf[0]);
    end
  endtask

  task automatic test_repeated_start_read;
    int unsigned acks;
    do_read(MY, 1'b1, 8'h05, 2, acks);
    m_read(1'b1, 5, 2);
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL rs_acks: got %0d required 3", acks);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_buf[i] !== exp_buf[i]) begin
        errors++; $display("FAIL rs_byte%0d: got %02h required %02h", i, rd_buf[i], exp_buf[i]);
      end
    end
    checks++;
    if (post_bit !== 1'b1) begin
      errors++; $display("FAIL rs_release_after_nack: sda=%0b required 1", post_bit);
    end
  endtask

  task automatic test_wrong_addr;
    int unsigned acks;
    wr_buf[0] = 8'h5A; wr_buf[1] = 8'hC3;
    do_write(7'h12, 8'h03, 2, acks);
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL wrong_addr_acks: got %0d required 0", acks);
    end
  endtask

  task automatic test_wrap;
    int unsigned acks;
    wr_buf[0] = 8'hAA; wr_buf[1] = 8'hBB;
    do_write(MY, 8'h0F, 2, acks);
    m_write(15, 2);
    checks++;
    if (acks !== 4) begin
      errors++; $display("FAIL wrap_acks: got %0d required 4", acks);
    end
    do_read(MY, 1'b1, 8'h0F, 2, acks);
    m_read(1'b1, 15, 2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_buf[i] !== exp_buf[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %02h required %02h", i, rd_buf[i], exp_buf[i]);
      end
    end
  endtask

  task automatic test_random;
    int unsigned acks, op, n, r;
    logic [6:0] bad;
    for (int it = 0; it < 8; it++) begin
      op = $urandom_range(0, 2);
      r  = $urandom_range(0, 255);
      if (op == 0) begin
        n = $urandom_range(1, 4);
        for (int unsigned i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
        do_write(MY, 8'(r), n, acks);
        m_write(r, n);
        checks++;
        if (acks !== n + 2) begin
          errors++; $display("FAIL rand_write_acks: got %0d required %0d", acks, n + 2);
        end
      end else if (op == 1) begin
        n = $urandom_range(1, 3);
        do_read(MY, 1'b1, 8'(r), n, acks);
        m_read(1'b1, r, n);
        checks++;
        if (acks !== 3) begin
          errors++; $display("FAIL rand_read_acks: got %0d required 3", acks);
        end
        for (int unsigned i = 0; i < n; i++) begin
          checks++;
          if (rd_buf[i] !== exp_buf[i]) begin
            errors++; $display("FAIL rand_read_r%0d_b%0d: got %02h required %02h", r, i, rd_buf[i], exp_buf[i]);
          end
        end
      end else begin
        bad = MY ^ (7'd1 << $urandom_range(0, 6));
        for (int i = 0; i < 2; i++) wr_buf[i] = 8'($urandom);
        do_write(bad, 8'(r), 2, acks);
        checks++;
        if (acks !== 0) begin
          errors++; $display("FAIL rand_bad_addr_acks: addr=%02h got %0d required 0", bad, acks);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic ok;
    logic [7:0] b, rv;
    // STOP in the middle of a data byte
    i2c_start;
    wbyte({MY, 1'b0}, ok);
    wbyte(8'h03, ok);
    m_write(3, 0);
    b = 8'($urandom);
    for (int i = 7; i >= 4; i--) wbit(b[i]);
    i2c_stop;
    repeat (4) @(negedge clk);
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++; $display("FAIL stop_midbyte_release: sda=%0b required 1", sda_bus);
    end
    // reset asserted while the slave holds an ACK
    i2c_start;
    wbyte({MY, 1'b0}, ok);
    wbyte(8'h02, ok);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    ctl_oe = 1'b0; #Q; scl = 1'b1; #Q;
    checks++;
    if (sda_bus !== 1'b0) begin
      errors++; $display("FAIL ack_before_reset: sda=%0b required 0", sda_bus);
    end
    @(negedge clk);
    rv = 8'($urandom);
    rst_val = rv; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++; $display("FAIL reset_release: sda=%0b required 1", sda_bus);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_reset(rv);
    scl = 1'b0; #Q;
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++; $display("FAIL after_reset_release: sda=%0b required 1", sda_bus);
    end
    i2c_stop;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_readback_all("reset");
    test_write_burst;
    test_readback_all("burst");
    test_repeated_start_read;
    test_wrong_addr;
    test_readback_all("wrong_addr");
    test_wrap;
    test_random;
    test_readback_all("random");
    test_abort;
    test_readback_all("abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (slave) with an internal byte-wide register file, oversampling SCL/SDA on a fast system clock.
- Supports multi-byte writes with an auto-incrementing register pointer, and reads via repeated START.
- Sits on a board-level open-drain I2C bus. The 7-bit bus address is a port, so several instances can share a bus.

Parameters:
- DEPTH, 16, number of 8-bit registers. Register pointer wraps modulo DEPTH; power of two required.

Ports:
- clk  in  1  system clock; frequency >= 4x SCL frequency.
- rst  in  1  reset, synchronous, active-high.
- scl  in  1  I2C clock from the controller; asynchronous to clk.
- sda  inout  1  I2C data, open-drain: the block drives 0 or Z only, never 1.
- slave_addr  in  7  own bus address; compared on every address phase.
- rst_val  in  8  value loaded into every register and into the pointer on reset.

Behaviour:
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer, plus a previous-value flop for edge detection.
  - All events are evaluated on the synchronized signals.
- Bus conditions:
  - START / repeated START: sda falls while scl is high. From any state, go to ADDR with bit counter cleared.
  - STOP: sda rises while scl is high. From any state, go to IDLE and release sda.
- Bit timing:
  - Receive bits are sampled on the scl rising edge, MSB first.
  - Driven bits (ACK, read data) change only on the scl falling edge.
- Reset (rst=1 at a clk edge):
  - State returns to IDLE; sda is released (Z).
  - All registers are loaded with rst_val; pointer is loaded with rst_val modulo DEPTH.
  - Bit counter is cleared.
  - Reset mid-transfer aborts the transfer; the bus is not driven again until the next START.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: shift in 8 bits (7 address bits, then R/W). At the falling edge after bit 8:
    - address == slave_addr: drive sda=0 and go to ADDR_ACK.
    - otherwise: go to IDLE, stay released, ignore bus until next START.
  - ADDR_ACK: hold sda=0 through the 9th clock. On the following falling edge:
    - R/W=0: release sda, go to REG.
    - R/W=1: load shift register from reg[pointer], drive MSB, go to RDATA.
  - REG: shift in 8 bits; pointer <= byte modulo DEPTH; ACK (sda=0 for the 9th clock), then go to WDATA.
  - WDATA:
    - Shift in 8 bits; write reg[pointer] <= byte on the falling edge after bit 8.
    - Then pointer <= pointer+1 (wraps DEPTH-1 -> 0), ACK, stay in WDATA.
    - Unlimited bytes allowed.
  - RDATA: drive 8 bits MSB first. On the falling edge after bit 8, release sda and go to RACK.
  - RACK: sample controller's bit on the scl rising edge.
    - 0 (ACK): pointer <= pointer+1 (wrap), load the next byte, go to RDATA on the falling edge.
    - 1 (NACK): go to IDLE with sda released.
- Repeated START after a REG phase keeps the pointer; the following read begins at that register.
- START or STOP while driving sda: release sda within 1 clk of detection.
- Register file is internal only; no host-side port.

Test Plan:
- Reset with rst_val=0x00, scl=sda=1 -> sda stays Z; no ACK without a START; reads later return 0x00 for untouched registers.
- START, address 0x11+W, reg 0x00, data 0x01..0x08, STOP -> ACK (sda=0) on all 10 ninth clocks; reg[0..7]=0x01..0x08; pointer=8.
- START, 0x11+W, reg 0x05, repeated START, 0x11+R -> ACK on all 3 address/reg bytes; slave drives 0x06 MSB first. Controller ACK -> next byte 0x07; NACK -> sda released and state IDLE.
- START, address 0x12+W -> no ACK (sda stays 1 on the 9th clock); subsequent bytes ignored and no registers change.
- Write from reg DEPTH-1 with 2 data bytes 0xAA,0xBB -> reg[DEPTH-1]=0xAA, reg[0]=0xBB (pointer wrap).
- STOP in the middle of a data byte, then rst asserted during an ACK -> partial byte discarded and sda released within 1 clk; after reset, registers all equal rst_val.
